// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result-retire stage.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned NUM_REGS = 32;

  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   result;
    logic [FLAG_W-1:0] flags;
  } wb_entry_t;

  typedef struct packed {
    logic [RADDR_W-1:0] dest;
    logic               we;
    logic               trap;
  } wb_decode_t;

  // Destination, write-enable and overflow-trap decode for one retired entry.
  function automatic wb_decode_t wb_decode(input logic [5:0]         op,
                                           input logic [5:0]         fn,
                                           input logic [RADDR_W-1:0] rt,
                                           input logic [RADDR_W-1:0] rd,
                                           input logic               ovf);
    wb_decode_t d;
    logic       no_write;
    d.dest   = (op == OP_RTYPE) ? rd : rt;
    no_write = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LW) || (op == OP_SW) ||
               ((op == OP_RTYPE) && (fn == FN_JR));
    d.trap   = ovf && (((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB))) ||
                       (op == OP_ADDI));
    d.we     = !no_write && !d.trap && (d.dest != '0);
    return d;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for retire triples; extra pointer bit separates full from empty.
module wb_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t wdata_i,
  output wb_entry_t rdata_o,
  output logic      empty_o,
  output logic      ready_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ready_q;
  logic            push, pop, full_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign ready_o = ready_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign push    = push_i && ready_q;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Ready is registered from next occupancy so a pop never raises it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result-retire stage: input FIFO, destination decode, register file, retire counters.
// Optional macro ALU_WB_BYPASS_EN makes the read ports write-through for the entry retiring this cycle.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instruction,
  input  logic [XLEN-1:0]      in_result,
  input  logic [FLAG_W-1:0]    in_flags,
  input  logic                 wb_stall,
  input  logic                 flags_clear,
  input  logic [RADDR_W-1:0]   rd_addr_a,
  input  logic [RADDR_W-1:0]   rd_addr_b,
  output logic [XLEN-1:0]      rd_data_a,
  output logic [XLEN-1:0]      rd_data_b,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [RADDR_W-1:0]   wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic [FLAG_W-1:0]    sticky_flags,
  output logic                 overflow_trap,
  output logic [XLEN-1:0]      retired_count
);

  wb_entry_t           in_entry, head;
  wb_decode_t          dec;
  logic                empty, pop;
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic                wb_valid_q, wb_we_q, trap_q;
  logic [RADDR_W-1:0]  wb_addr_q;
  logic [XLEN-1:0]     wb_data_q, count_q;
  logic [FLAG_W-1:0]   sticky_q, sticky_d;
  logic                unused_instr_bits;

  assign in_entry = '{instr: in_instruction, result: in_result, flags: in_flags};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (pop),
    .wdata_i (in_entry),
    .rdata_o (head),
    .empty_o (empty),
    .ready_o (in_ready)
  );

  assign pop = !empty && !wb_stall;
  assign dec = wb_decode(head.instr[31:26], head.instr[5:0], head.instr[20:16],
                         head.instr[15:11], head.flags[FLAG_OVF]);
  assign unused_instr_bits = ^{head.instr[25:21], head.instr[10:6]};

  always_comb begin
    sticky_d = sticky_q;
    if (pop) sticky_d = flags_clear ? head.flags : (sticky_q | head.flags);
    else if (flags_clear) sticky_d = '0;
  end

  // Register 0 is never written because the decode clears we for dest 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (pop && dec.we) begin
      regs_q[dec.dest] <= head.result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      sticky_q   <= '0;
      trap_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      wb_valid_q <= pop;
      sticky_q   <= sticky_d;
      if (pop) begin
        wb_we_q   <= dec.we;
        wb_addr_q <= dec.dest;
        wb_data_q <= head.result;
        count_q   <= count_q + XLEN'(1);
        if (dec.trap) trap_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
`ifdef ALU_WB_BYPASS_EN
    if (pop && dec.we && (dec.dest == rd_addr_a)) rd_data_a = head.result;
    if (pop && dec.we && (dec.dest == rd_addr_b)) rd_data_b = head.result;
`endif
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end

  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign sticky_flags  = sticky_q;
  assign overflow_trap = trap_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus random traffic against a queue-based model.
module tb_alu_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_result = '0;
  logic [2:0]  in_flags = '0;
  logic        wb_stall = 1'b0;
  logic        flags_clear = 1'b0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  sticky_flags;
  logic        overflow_trap;
  logic [31:0] retired_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_result(in_result), .in_flags(in_flags),
    .wb_stall(wb_stall), .flags_clear(flags_clear),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .sticky_flags(sticky_flags), .overflow_trap(overflow_trap),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] result;
    logic [2:0]  flags;
  } trip_t;

  trip_t       q[$];
  logic [31:0] m_regs [32];
  logic        m_ready, m_wbv, m_we, m_trap;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_count;
  logic [2:0]  m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_decode(input logic [31:0] ins, input logic [2:0] fl,
                                   output logic [4:0] d, output logic we, output logic trap);
    logic [5:0] op, fn;
    op   = ins[31:26];
    fn   = ins[5:0];
    d    = (op == 6'h00) ? ins[15:11] : ins[20:16];
    we   = 1'b1;
    trap = 1'b0;
    if (op == 6'h04 || op == 6'h05 || op == 6'h2b || op == 6'h23) we = 1'b0;
    if (op == 6'h00 && fn == 6'h08) we = 1'b0;
    if (fl[0] && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08)) begin
      trap = 1'b1;
      we   = 1'b0;
    end
    if (d == 5'd0) we = 1'b0;
  endfunction

  // Reference model: advances one retire/push step per edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_ready = 1'b1; m_wbv = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
      m_count = '0; m_sticky = '0; m_trap = 1'b0;
    end else begin
      trip_t      e;
      logic [4:0] d;
      logic       we, trap;
      bit         do_pop, do_push;
      do_pop  = (q.size() > 0) && !wb_stall;
      do_push = in_valid && m_ready;
      m_wbv   = 1'b0;
      if (do_pop) begin
        e = q.pop_front();
        m_decode(e.instr, e.flags, d, we, trap);
        m_wbv = 1'b1; m_we = we; m_addr = d; m_data = e.result;
        if (we) m_regs[d] = e.result;
        if (trap) m_trap = 1'b1;
        m_count  = m_count + 32'd1;
        m_sticky = flags_clear ? e.flags : (m_sticky | e.flags);
      end else if (flags_clear) begin
        m_sticky = '0;
      end
      if (do_push) q.push_back('{instr: in_instruction, result: in_result, flags: in_flags});
      m_ready = (q.size() != DEPTH);
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef ALU_WB_BYPASS_EN
    if (q.size() > 0 && !wb_stall) begin
      logic [4:0] d;
      logic       we, trap;
      m_decode(q[0].instr, q[0].flags, d, we, trap);
      if (we && d == a) return q[0].result;
    end
`endif
    return m_regs[a];
  endfunction

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("wb_valid", 32'(wb_valid), 32'(m_wbv));
    if (m_wbv) begin
      check("wb_we", 32'(wb_we), 32'(m_we));
      check("wb_addr", 32'(wb_addr), 32'(m_addr));
      check("wb_data", wb_data, m_data);
    end
    check("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
    check("overflow_trap", 32'(overflow_trap), 32'(m_trap));
    check("retired_count", retired_count, m_count);
    check("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    check("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] res, input logic [2:0] fl);
    in_valid = 1'b1; in_instruction = ins; in_result = res; in_flags = fl;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] addu_rd(input logic [4:0] rd);
    return {6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2b};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h08, 6'h2a};
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 9) == 0) ins[31:26] = 6'h0d;
    if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 5)];
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_count", retired_count, 32'd0);

    // addu rd=4, result all ones
    tick();
    rd_addr_a = 5'd4;
    drive(32'h0001_2021, 32'hFFFF_FFFF, 3'b000);
    tick();
    @(negedge clk);
    check("addu_valid", 32'(wb_valid), 32'd1);
    check("addu_we", 32'(wb_we), 32'd1);
    check("addu_addr", 32'(wb_addr), 32'd4);
    check("addu_reg4", rd_data_a, 32'hFFFF_FFFF);

    // addi trapping overflow, then addiu ignoring it
    tick();
    rd_addr_a = 5'd5;
    drive(32'h2005_0001, 32'h8000_0000, 3'b001);
    tick();
    @(negedge clk);
    check("addi_we", 32'(wb_we), 32'd0);
    check("addi_trap", 32'(overflow_trap), 32'd1);
    check("addi_reg5", rd_data_a, 32'd0);
    tick();
    drive(32'h2405_0001, 32'h8000_0000, 3'b001);
    tick();
    @(negedge clk);
    check("addiu_we", 32'(wb_we), 32'd1);
    check("addiu_reg5", rd_data_a, 32'h8000_0000);
    check("addiu_trap", 32'(overflow_trap), 32'd1);

    // fill the FIFO under stall, try a fifth push, then drain
    tick();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) drive(addu_rd(5'(6 + i)), 32'(100 + i), 3'b000);
    @(negedge clk);
    check("full_ready", 32'(in_ready), 32'd0);
    tick();
    drive(addu_rd(5'd11), 32'hDEAD_BEEF, 3'b000);
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("drain_valid", 32'(wb_valid), 32'd1);
      check("drain_data", wb_data, 32'(100 + i));
    end
    tick();
    @(negedge clk);
    check("drain_idle", 32'(wb_valid), 32'd0);
    check("drain_count", retired_count, 32'd7);

    // rd=0 never writes
    tick();
    rd_addr_a = 5'd0;
    drive(32'h0000_0021, 32'h0000_1234, 3'b000);
    tick();
    @(negedge clk);
    check("r0_we", 32'(wb_we), 32'd0);
    check("r0_read", rd_data_a, 32'd0);

    // sticky flags accumulate, then clear coinciding with a retire
    tick();
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    drive(32'h1000_0000, 32'd1, 3'b100);
    drive(32'h1000_0000, 32'd2, 3'b010);
    tick();
    @(negedge clk);
    check("sticky_or", 32'(sticky_flags), 32'b110);
    tick();
    drive(32'h1000_0000, 32'd3, 3'b001);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    @(negedge clk);
    check("sticky_clear_retire", 32'(sticky_flags), 32'b001);

    // reset with entries buffered under stall
    tick();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) drive(addu_rd(5'(12 + i)), 32'(200 + i), 3'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", retired_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("rst_no_valid", 32'(wb_valid), 32'd0);
    end

    // same-cycle read of a register being written
    tick();
    rd_addr_a = 5'd10;
    drive(addu_rd(5'd10), 32'hCAFE_F00D, 3'b000);
    @(negedge clk);
`ifdef ALU_WB_BYPASS_EN
    check("bypass_read", rd_data_a, 32'hCAFE_F00D);
`else
    check("nobypass_read", rd_data_a, 32'd0);
`endif
    tick();
    @(negedge clk);
    check("after_write_read", rd_data_a, 32'hCAFE_F00D);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      in_valid       = ($urandom_range(0, 3) != 0);
      in_instruction = rand_instr();
      in_result      = $urandom;
      in_flags       = 3'($urandom);
      wb_stall       = ($urandom_range(0, 3) == 0);
      flags_clear    = ($urandom_range(0, 19) == 0);
      rd_addr_a      = 5'($urandom);
      rd_addr_b      = 5'($urandom);
      rst            = ($urandom_range(0, 499) == 0);
    end
    tick();
    in_valid = 1'b0; wb_stall = 1'b0; flags_clear = 1'b0; rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
